alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Parametrised iterative multiply/divide companion to the single-cycle ALU.
- Supports signed and unsigned multiply and divide, and keeps the full double-width result in architectural HI/LO registers. The single-cycle ALU only returns the low product word and quotient.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
- Uses a start/busy/done handshake and a flush input for exception squashing.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled on each rising edge.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved.
- a  in  WIDTH  multiplicand/dividend; data for MTHI/MTLO.
- b  in  WIDTH  multiplier/divisor.
- flush  in  1  abort any in-flight operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: hi/lo just updated.
- hi  out  WIDTH  HI register (product upper word / remainder).
- lo  out  WIDTH  LO register (product lower word / quotient).

Behaviour:
- Reset (reset==0 at an edge) takes priority over everything. It forces busy=0, done=0, hi=0, lo=0 and state IDLE, and aborts any in-flight operation.
- States: IDLE, RUN, FIX.
- Accept condition: an edge with start=1, busy=0, flush=0, reset=1.
  - Operands and op are latched at accept; a/b may change afterwards without effect.
- MULT/MULTU/DIV/DIVU at accept:
  - IDLE->RUN, busy=1 from the next cycle.
  - The counter loads WIDTH.
  - Signed ops latch operand magnitudes and record the result signs.
- RUN performs one iteration per cycle for WIDTH cycles:
  - Multiply: shift-add.
  - Divide: restoring.
  - At the last iteration (counter==1) go RUN->FIX.
- FIX applies sign correction:
  - Signed product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - At the FIX edge, hi/lo are written and done=1 for exactly one cycle; busy falls at that same edge; state returns to IDLE.
- Latency: accept at edge E0 -> hi/lo valid and done=1 in the cycle after edge E0+WIDTH+1.
- MTHI/MTLO: at the accept edge hi (or lo) <= a. The other register is unchanged. busy stays 0 and done=1 for the following cycle.
- Reserved op: ignored; no state change, no done.
- start while busy=1: ignored. No queueing; the requester must re-assert.
- Divide by zero (b==0, signed or unsigned): detected at accept, same latency. Result lo = all ones, hi = a unmodified.
- Signed overflow (DIV with a = most negative, b = -1): lo = a (most negative), hi = 0, no trap.
- All arithmetic is modulo 2^WIDTH per word; the product is exactly 2*WIDTH bits {hi,lo}.
- flush=1 at an edge:
  - If busy: state->IDLE, busy=0 next cycle, hi/lo unchanged, no done.
  - A start on the same edge is ignored.
  - flush has no effect in IDLE.
- Back-to-back: a new start may be accepted in the cycle done=1 is high, since busy=0 there.
- hi/lo change only on done edges, MTHI/MTLO accepts, or reset.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF (WIDTH=32) -> done exactly 33 edges after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Start the second op in the done cycle of the first; it must be accepted.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 then MTLO a=0x5678 -> hi=0x1234, lo=0x5678; each gives a one-cycle done with busy=0. Reserved op 110 -> no change, no done.
- Start DIVU 100/7; at cycle 10 assert flush and, on the same edge, a start -> busy=0 next cycle, no done, hi/lo keep prior values, the new start is not accepted. Also pulse start mid-run without flush -> ignored; the original result (lo=14, hi=2) completes unchanged.
- reset=0 mid-MULT at cycle 5 -> busy=0, done=0, hi=lo=0 after that edge. A fresh MULTU 6*7 after reset release -> lo=42, hi=0.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Handshake/data bundle between the execute stage and the iterative
// multiply/divide unit.
//   start  - request, sampled on each rising clock edge
//   op     - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved
//   a, b   - multiplicand/dividend (MTHI/MTLO data), multiplier/divisor
//   flush  - abort an in-flight operation
//   busy   - operation in progress
//   done   - one-cycle pulse, hi/lo just updated
//   hi, lo - architectural HI/LO registers
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative signed/unsigned multiply and divide unit with architectural
// HI/LO registers. One shift-add or restoring-divide step per cycle for
// WIDTH cycles, then one sign-correction cycle that writes HI/LO.
// Ports:
//   clk_i     - rising-edge clock
//   reset_ni  - synchronous, active-low reset
//   bus       - alu_muldiv_seq_if.slave (start/op/a/b/flush in,
//               busy/done/hi/lo out)
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    alu_muldiv_seq_if.slave      bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // remainder takes dividend sign
    logic             dz_q, dz_d;             // divide by zero
    // acc = product upper half / partial remainder
    // mq  = multiplier bits     / dividend bits shifting into quotient
    // opnd = multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand sign handling (op[0] selects the signed variants)
    always_comb begin
        sa    = bus.op[0] & bus.a[WIDTH-1];
        sb    = bus.op[0] & bus.b[WIDTH-1];
        mag_a = sa ? -bus.a : bus.a;
        mag_b = sb ? -bus.b : bus.b;
    end

    // Iteration datapath and sign-correction results
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_q, mq_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ok   = ~div_diff[WIDTH];
        prod     = {acc_q, mq_q};
        prod_fix = neg_res_q ? -prod : prod;
        quot_fix = neg_res_q ? -mq_q : mq_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d   = S_RUN;
                            cnt_d     = CNT_W'(WIDTH);
                            is_div_d  = bus.op[1];
                            neg_res_d = sa ^ sb;
                            neg_rem_d = sa;
                            dz_d      = bus.op[1] && (bus.b == '0);
                            acc_d     = '0;
                            mq_d      = mag_a;
                            opnd_d    = mag_b;
                        end
                        3'b100: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], div_ok};
                    end else begin
                        {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        // With a zero divisor the restoring loop leaves |a| in the
                        // remainder, so the dividend-sign fix-up returns a itself;
                        // only the quotient needs forcing to all ones.
                        lo_d = dz_q ? '1 : quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq (WIDTH=32): table of operations run
// back-to-back with a result scoreboard, plus hand-written sequences for
// reserved op, flush, start-while-busy and mid-operation reset.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic clk;
    logic reset_n;

    alu_muldiv_seq_if #(.WIDTH(W)) bus();

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } vec_t;

    res_t sb_q[$];
    vec_t vecs[14];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Drive a request at the current negedge; accepted at the next posedge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare hi/lo.
    task automatic wait_done(input string name, output int lat, output int bcnt);
        res_t e;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, lat);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done seen with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " hi"}, bus.hi, e.hi);
            check({name, " lo"}, bus.lo, e.lo);
            check({name, " busy@done"}, W'(bus.busy), W'(0));
        end
    endtask

    // Watch for n cycles: count done pulses and busy cycles.
    task automatic idle_watch(input int n, output int dcnt, output int bcnt);
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
            if (bus.busy === 1'b1) bcnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bc, dc;

        //            op      a             b             hi            lo            lat
        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'b010, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 33};
        vecs[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{3'b100, 32'h00001234, 32'h0,        32'h00001234, 32'h80000000, 0};
        vecs[6]  = '{3'b101, 32'h00005678, 32'h0,        32'h00001234, 32'h00005678, 0};
        vecs[7]  = '{3'b010, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[8]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{3'b000, 32'd6,        32'd7,        32'd0,        32'd42,       33};
        vecs[10] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
        vecs[11] = '{3'b011, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 33};
        vecs[12] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[13] = '{3'b001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 33};

        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset hi", bus.hi, '0);
        check("reset lo", bus.lo, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Each op is issued in the done cycle of the previous one.
        for (int i = 0; i < 14; i++) begin
            sb_q.push_back('{hi: vecs[i].hi, lo: vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), lat, bc);
            check($sformatf("vec%0d latency", i), W'(lat), W'(vecs[i].lat));
            check($sformatf("vec%0d busy cycles", i), W'(bc), W'(vecs[i].lat));
        end
        @(negedge clk);
        check("done one-cycle", W'(bus.done), W'(0));

        // Reserved op: nothing happens.
        issue(3'b110, 32'hDEADBEEF, 32'h1);
        idle_watch(5, dc, bc);
        check("reserved done", W'(dc), W'(0));
        check("reserved busy", W'(bc), W'(0));
        check("reserved hi", bus.hi, vecs[13].hi);
        check("reserved lo", bus.lo, vecs[13].lo);

        // Flush mid-divide with a simultaneous start.
        issue(3'b010, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush busy", W'(bus.busy), W'(0));
        check("flush done", W'(bus.done), W'(0));
        idle_watch(40, dc, bc);
        check("flush later done", W'(dc), W'(0));
        check("flush start ignored", W'(bc), W'(0));
        check("flush hi", bus.hi, vecs[13].hi);
        check("flush lo", bus.lo, vecs[13].lo);

        // Start pulsed while busy is ignored.
        sb_q.push_back('{hi: 32'd2, lo: 32'd14});
        issue(3'b010, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy-start", lat, bc);
        check("busy-start latency", W'(lat), W'(28));
        idle_watch(40, dc, bc);
        check("busy-start extra done", W'(dc), W'(0));
        check("busy-start extra busy", W'(bc), W'(0));

        // Reset mid-multiply.
        issue(3'b001, 32'hFFFFFFFD, 32'd5);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset busy", W'(bus.busy), W'(0));
        check("midreset done", W'(bus.done), W'(0));
        check("midreset hi", bus.hi, '0);
        check("midreset lo", bus.lo, '0);
        sb_q.push_back('{hi: 32'd0, lo: 32'd42});
        issue(3'b000, 32'd6, 32'd7);
        wait_done("post-reset multu", lat, bc);
        check("post-reset latency", W'(lat), W'(33));

        check("scoreboard drained", W'(sb_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
